// File: rtl/axilite_log_merger.sv
// ---------------------------------------------------------------------------
// axilite_log_merger
//
// Merges the five AXI4-Lite logging streams (AR, AW, W, R, B) into a single
// tagged record stream. A round-robin arbiter picks one stream per cycle.
// The accepted beat is stored in a one-entry output register as
// {tag[2:0], timestamp, payload}. The register sustains one record per cycle.
//
// Optional feature: define AXILITE_LOG_MERGER_TS_EN to build the free-running
// timestamp counter and include the ts field in each record. When the macro
// is undefined there is no counter, the record is {tag, payload}, and
// TS_WIDTH has no effect.
//
// Ports:
//   clk, rst_n                  - clock and synchronous active-low reset
//   logging_<ch>valid/ready     - per-stream handshake (ch = ar, aw, w, r, b)
//   logging_<ch>_payload        - per-stream payload, zero-extended into record
//   out_valid / out_ready       - record stream handshake
//   out_data                    - {tag, [ts,] payload}, MSB first
//   record_count                - records handed off at the output (wraps)
// ---------------------------------------------------------------------------
module axilite_log_merger #(
    parameter int A_PAYLOAD_FORMANTTED_WIDTH = 64,
    parameter int W_PAYLOAD_FORMANTTED_WIDTH = 64,
    parameter int R_PAYLOAD_FORMANTTED_WIDTH = 64,
    parameter int B_PAYLOAD_FORMANTTED_WIDTH = 64,
    parameter int PAYLOAD_WIDTH              = 64,
    parameter int TS_WIDTH                   = 32,
`ifdef AXILITE_LOG_MERGER_TS_EN
    localparam bit TS_EN = 1'b1,
`else
    localparam bit TS_EN = 1'b0,
`endif
    localparam int TS_FIELD_WIDTH = TS_EN ? TS_WIDTH : 0,
    localparam int OUT_WIDTH      = 3 + TS_FIELD_WIDTH + PAYLOAD_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic                                  logging_arvalid,
    output logic                                  logging_arready,
    input  logic [A_PAYLOAD_FORMANTTED_WIDTH-1:0] logging_ar_payload,

    input  logic                                  logging_awvalid,
    output logic                                  logging_awready,
    input  logic [A_PAYLOAD_FORMANTTED_WIDTH-1:0] logging_aw_payload,

    input  logic                                  logging_wvalid,
    output logic                                  logging_wready,
    input  logic [W_PAYLOAD_FORMANTTED_WIDTH-1:0] logging_w_payload,

    input  logic                                  logging_rvalid,
    output logic                                  logging_rready,
    input  logic [R_PAYLOAD_FORMANTTED_WIDTH-1:0] logging_r_payload,

    input  logic                                  logging_bvalid,
    output logic                                  logging_bready,
    input  logic [B_PAYLOAD_FORMANTTED_WIDTH-1:0] logging_b_payload,

    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_WIDTH-1:0]                  out_data,
    output logic [31:0]                           record_count
);

    // Stream tags, also used as the arbiter's channel indices.
    localparam logic [2:0] TAG_AR = 3'd0;
    localparam logic [2:0] TAG_AW = 3'd1;
    localparam logic [2:0] TAG_W  = 3'd2;
    localparam logic [2:0] TAG_R  = 3'd3;
    localparam logic [2:0] TAG_B  = 3'd4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t             state;
    logic [2:0]             last_grant;
    logic [2:0]             grant;
    logic [2:0]             cand;
    logic                   grant_valid;
    logic                   can_load;
    logic                   accept;
    logic                   handoff;
    logic [4:0]             valid_vec;
    logic [4:0]             ready_vec;
    logic [PAYLOAD_WIDTH-1:0] grant_payload;
    logic [OUT_WIDTH-1:0]   next_record;

`ifdef AXILITE_LOG_MERGER_TS_EN
    logic [TS_WIDTH-1:0]    ts_cnt;
`endif

    // Reduces a value in 0..9 to 0..4; used to step around the five tags.
    function automatic logic [2:0] wrap5(input logic [3:0] v);
        logic [3:0] r;
        r = (v >= 4'd5) ? (v - 4'd5) : v;
        return r[2:0];
    endfunction

    assign valid_vec = {logging_bvalid, logging_rvalid, logging_wvalid,
                        logging_awvalid, logging_arvalid};

    assign out_valid = (state == FULL);
    assign can_load  = !out_valid || out_ready;
    assign handoff   = out_valid && out_ready;

    // Round-robin search starting one past the last winner; the first
    // asserted valid in that order takes the grant.
    always_comb begin
        grant_valid = 1'b0;
        grant       = last_grant;
        cand        = '0;
        for (int i = 1; i <= 5; i++) begin
            cand = wrap5({1'b0, last_grant} + 4'(i));
            if (!grant_valid && valid_vec[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    // Only the granted stream sees a ready, and only when the output
    // register can take a new record. Reset forces every ready low.
    assign ready_vec = (rst_n && grant_valid && can_load) ? (5'b00001 << grant) : 5'b00000;
    assign accept    = rst_n && grant_valid && can_load;

    assign logging_arready = ready_vec[TAG_AR];
    assign logging_awready = ready_vec[TAG_AW];
    assign logging_wready  = ready_vec[TAG_W];
    assign logging_rready  = ready_vec[TAG_R];
    assign logging_bready  = ready_vec[TAG_B];

    // Payload of the granted stream, zero-extended to the record field.
    always_comb begin
        grant_payload = '0;
        case (grant)
            TAG_AR:  grant_payload = PAYLOAD_WIDTH'(logging_ar_payload);
            TAG_AW:  grant_payload = PAYLOAD_WIDTH'(logging_aw_payload);
            TAG_W:   grant_payload = PAYLOAD_WIDTH'(logging_w_payload);
            TAG_R:   grant_payload = PAYLOAD_WIDTH'(logging_r_payload);
            TAG_B:   grant_payload = PAYLOAD_WIDTH'(logging_b_payload);
            default: grant_payload = '0;
        endcase
    end

`ifdef AXILITE_LOG_MERGER_TS_EN
    assign next_record = {grant, ts_cnt, grant_payload};
`else
    assign next_record = {grant, grant_payload};
`endif

    // Output register, arbiter history, handoff counter and timestamp.
    // A new record may load in the same cycle the previous one leaves, so
    // the register stays FULL across back-to-back traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            out_data     <= '0;
            record_count <= '0;
            last_grant   <= TAG_B;
`ifdef AXILITE_LOG_MERGER_TS_EN
            ts_cnt       <= '0;
`endif
        end else begin
            if (accept) begin
                state      <= FULL;
                out_data   <= next_record;
                last_grant <= grant;
            end else if (handoff) begin
                state      <= EMPTY;
            end

            if (handoff) begin
                record_count <= record_count + 32'd1;
            end

`ifdef AXILITE_LOG_MERGER_TS_EN
            ts_cnt <= ts_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_axilite_log_merger.sv
// ---------------------------------------------------------------------------
// tb_axilite_log_merger
//
// Directed bench for axilite_log_merger. A second instance built with
// TS_WIDTH = 4 shares all inputs with the main instance so that timestamp
// wrap can be observed. Timestamp fields are only checked when
// AXILITE_LOG_MERGER_TS_EN is defined.
// ---------------------------------------------------------------------------
module tb_axilite_log_merger;

`ifdef AXILITE_LOG_MERGER_TS_EN
    localparam int OUT_W  = 3 + 32 + 64;
    localparam int OUT_W4 = 3 + 4 + 64;
`else
    localparam int OUT_W  = 3 + 64;
    localparam int OUT_W4 = 3 + 64;
`endif

    logic              clk;
    logic              rst_n;
    logic              arvalid, awvalid, wvalid, rvalid, bvalid;
    logic [63:0]       ar_payload, aw_payload, w_payload, r_payload, b_payload;
    logic              out_ready;

    logic              arready, awready, wready, rready, bready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [31:0]       record_count;

    logic              arready4, awready4, wready4, rready4, bready4;
    logic              out_valid4;
    logic [OUT_W4-1:0] out_data4;
    logic [31:0]       record_count4;

    logic [4:0]        rdy;

    int n_compared;
    int n_mismatched;

    assign rdy = {bready, rready, wready, awready, arready};

    axilite_log_merger dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .logging_arvalid    (arvalid),
        .logging_arready    (arready),
        .logging_ar_payload (ar_payload),
        .logging_awvalid    (awvalid),
        .logging_awready    (awready),
        .logging_aw_payload (aw_payload),
        .logging_wvalid     (wvalid),
        .logging_wready     (wready),
        .logging_w_payload  (w_payload),
        .logging_rvalid     (rvalid),
        .logging_rready     (rready),
        .logging_r_payload  (r_payload),
        .logging_bvalid     (bvalid),
        .logging_bready     (bready),
        .logging_b_payload  (b_payload),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .record_count       (record_count)
    );

    axilite_log_merger #(.TS_WIDTH(4)) dut_ts4 (
        .clk                (clk),
        .rst_n              (rst_n),
        .logging_arvalid    (arvalid),
        .logging_arready    (arready4),
        .logging_ar_payload (ar_payload),
        .logging_awvalid    (awvalid),
        .logging_awready    (awready4),
        .logging_aw_payload (aw_payload),
        .logging_wvalid     (wvalid),
        .logging_wready     (wready4),
        .logging_w_payload  (w_payload),
        .logging_rvalid     (rvalid),
        .logging_rready     (rready4),
        .logging_r_payload  (r_payload),
        .logging_bvalid     (bvalid),
        .logging_bready     (bready4),
        .logging_b_payload  (b_payload),
        .out_valid          (out_valid4),
        .out_ready          (out_ready),
        .out_data           (out_data4),
        .record_count       (record_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic all_valids(input logic v);
        arvalid = v; awvalid = v; wvalid = v; rvalid = v; bvalid = v;
    endtask

    task automatic set_payloads();
        ar_payload = 64'hA0; aw_payload = 64'hA1; w_payload = 64'hA2;
        r_payload  = 64'hA3; b_payload  = 64'hA4;
    endtask

    // Leaves the bench just after the edge that starts cycle 0 (ts = 0).
    task automatic do_reset();
        all_valids(1'b0);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_payloads();
        all_valids(1'b1);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_compared++;
            if (rdy !== 5'b00000) begin
                n_mismatched++;
                $display("[TB] FAIL reset_readies cyc %0d: got %b expected 00000", c, rdy);
            end
            n_compared++;
            if (out_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_out_valid cyc %0d: got %b expected 0", c, out_valid);
            end
            n_compared++;
            if (record_count !== 32'd0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_record_count cyc %0d: got %0d expected 0", c, record_count);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_compared++;
        if (rdy !== 5'b00001) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release_arready: got %b expected 00001", rdy);
        end
        all_valids(1'b0);
    endtask

    task automatic test_single_ar();
        do_reset();
        repeat (3) next_cycle();
        arvalid    = 1'b1;
        ar_payload = 64'h1234;
        @(negedge clk);
        n_compared++;
        if (arready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_ready: got %b expected 1", arready);
        end
        next_cycle();
        arvalid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_valid: got %b expected 1", out_valid);
        end
        n_compared++;
        if (out_data[OUT_W-1 -: 3] !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_tag: got %0d expected 0", out_data[OUT_W-1 -: 3]);
        end
        n_compared++;
        if (out_data[63:0] !== 64'h1234) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_payload: got %h expected 1234", out_data[63:0]);
        end
`ifdef AXILITE_LOG_MERGER_TS_EN
        n_compared++;
        if (out_data[64 +: 32] !== 32'd3) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_ts: got %0d expected 3", out_data[64 +: 32]);
        end
`endif
        next_cycle();
        @(negedge clk);
        n_compared++;
        if (record_count !== 32'd1) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_count: got %0d expected 1", record_count);
        end
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_ar_empty: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_tag;
        logic [63:0] exp_pl;
        do_reset();
        set_payloads();
        all_valids(1'b1);
        for (int k = 1; k <= 11; k++) begin
            next_cycle();
            @(negedge clk);
            exp_tag = 3'((k - 1) % 5);
            exp_pl  = 64'hA0 + 64'((k - 1) % 5);
            n_compared++;
            if (out_valid !== 1'b1 || out_data[OUT_W-1 -: 3] !== exp_tag) begin
                n_mismatched++;
                $display("[TB] FAIL rr_tag cyc %0d: got valid %b tag %0d expected valid 1 tag %0d",
                         k, out_valid, out_data[OUT_W-1 -: 3], exp_tag);
            end
            n_compared++;
            if (out_data[63:0] !== exp_pl) begin
                n_mismatched++;
                $display("[TB] FAIL rr_payload cyc %0d: got %h expected %h", k, out_data[63:0], exp_pl);
            end
`ifdef AXILITE_LOG_MERGER_TS_EN
            n_compared++;
            if (out_data[64 +: 32] !== 32'(k - 1)) begin
                n_mismatched++;
                $display("[TB] FAIL rr_ts cyc %0d: got %0d expected %0d", k, out_data[64 +: 32], k - 1);
            end
`endif
        end
        all_valids(1'b0);
    endtask

    task automatic test_backpressure();
        do_reset();
        set_payloads();
        all_valids(1'b1);
        next_cycle();
        out_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_compared++;
            if (rdy !== 5'b00000) begin
                n_mismatched++;
                $display("[TB] FAIL bp_readies cyc %0d: got %b expected 00000", c, rdy);
            end
            n_compared++;
            if (out_valid !== 1'b1 || out_data[OUT_W-1 -: 3] !== 3'd0 || out_data[63:0] !== 64'hA0) begin
                n_mismatched++;
                $display("[TB] FAIL bp_hold cyc %0d: got valid %b tag %0d payload %h expected 1/0/a0",
                         c, out_valid, out_data[OUT_W-1 -: 3], out_data[63:0]);
            end
`ifdef AXILITE_LOG_MERGER_TS_EN
            n_compared++;
            if (out_data[64 +: 32] !== 32'd0) begin
                n_mismatched++;
                $display("[TB] FAIL bp_ts cyc %0d: got %0d expected 0", c, out_data[64 +: 32]);
            end
`endif
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_compared++;
        if (rdy !== 5'b00010) begin
            n_mismatched++;
            $display("[TB] FAIL bp_release_ready: got %b expected 00010", rdy);
        end
        next_cycle();
        all_valids(1'b0);
        @(negedge clk);
        n_compared++;
        if (out_data[OUT_W-1 -: 3] !== 3'd1 || out_data[63:0] !== 64'hA1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_next_record: got tag %0d payload %h expected 1/a1",
                     out_data[OUT_W-1 -: 3], out_data[63:0]);
        end
`ifdef AXILITE_LOG_MERGER_TS_EN
        n_compared++;
        if (out_data[64 +: 32] !== 32'd6) begin
            n_mismatched++;
            $display("[TB] FAIL bp_next_ts: got %0d expected 6", out_data[64 +: 32]);
        end
`endif
        n_compared++;
        if (record_count !== 32'd1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_count: got %0d expected 1", record_count);
        end
    endtask

    task automatic test_ts_wrap();
        do_reset();
        repeat (17) next_cycle();
        bvalid    = 1'b1;
        b_payload = 64'hBB;
        @(negedge clk);
        n_compared++;
        if (rdy !== 5'b10000) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_bready: got %b expected 10000", rdy);
        end
        next_cycle();
        bvalid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (out_valid4 !== 1'b1 || out_data4[OUT_W4-1 -: 3] !== 3'd4 || out_data4[63:0] !== 64'hBB) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_record: got valid %b tag %0d payload %h expected 1/4/bb",
                     out_valid4, out_data4[OUT_W4-1 -: 3], out_data4[63:0]);
        end
`ifdef AXILITE_LOG_MERGER_TS_EN
        n_compared++;
        if (out_data4[64 +: 4] !== 4'd1) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_ts4: got %0d expected 1", out_data4[64 +: 4]);
        end
        n_compared++;
        if (out_data[64 +: 32] !== 32'd17) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_ts32: got %0d expected 17", out_data[64 +: 32]);
        end
`endif
    endtask

    task automatic test_w_record();
        logic [OUT_W-1:0] exp_rec;
        do_reset();
        wvalid    = 1'b1;
        w_payload = 64'hFF;
        next_cycle();
        wvalid = 1'b0;
`ifdef AXILITE_LOG_MERGER_TS_EN
        exp_rec = {3'd2, 32'd0, 64'hFF};
`else
        exp_rec = {3'd2, 64'hFF};
`endif
        @(negedge clk);
        n_compared++;
        if (out_data !== exp_rec) begin
            n_mismatched++;
            $display("[TB] FAIL w_record: got %h expected %h", out_data, exp_rec);
        end
    endtask

    task automatic test_reset_mid_record();
        do_reset();
        out_ready  = 1'b0;
        arvalid    = 1'b1;
        ar_payload = 64'h55;
        next_cycle();
        arvalid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL mid_pending: got %b expected 1", out_valid);
        end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b0 || out_data !== '0 || record_count !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_discard: got valid %b data %h count %0d expected 0/0/0",
                     out_valid, out_data, record_count);
        end
        next_cycle();
        @(negedge clk);
        n_compared++;
        if (out_valid !== 1'b0 || record_count !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_no_emit: got valid %b count %0d expected 0/0", out_valid, record_count);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        out_ready    = 1'b1;
        all_valids(1'b0);
        set_payloads();

        test_reset();
        test_single_ar();
        test_round_robin();
        test_backpressure();
        test_ts_wrap();
        test_w_record();
        test_reset_mid_record();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
